seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 153 +++++++++++++++
 tb/tb_seq_alu.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
//   Sequential ALU. Non-shift operations complete one cycle after start.
//   Shifts by a non-zero amount are performed bit-serially, one bit per clock,
//   so a shift by N completes N+1 cycles after start.
//
// Parameters
//   XLEN        operand / result width (default 32)
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   start       request to begin an operation (ignored while busy)
//   ALUControl  operation code, sampled with start
//   SrcA, SrcB  operands, sampled with start (shift amount = SrcB[4:0])
//   busy        high while a shift is in progress
//   done        one-cycle pulse: ALUResult / Zero / illegal are valid
//   ALUResult   registered result, held until the next completion
//   Zero        registered (ALUResult == 0)
//   illegal     registered; set with done when the code was unsupported
// -----------------------------------------------------------------------------
module seq_alu #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [3:0]      ALUControl,
   input  logic [XLEN-1:0] SrcA,
   input  logic [XLEN-1:0] SrcB,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] ALUResult,
   output logic            Zero,
   output logic            illegal
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SH_SLL = 2'd0,
      SH_SRL = 2'd1,
      SH_SRA = 2'd2
   } shkind_t;

   state_t            state_q;
   shkind_t           kind_q;
   logic [XLEN-1:0]   work_q;
   logic [4:0]        cnt_q;
   logic [XLEN-1:0]   result_q;
   logic              zero_q;
   logic              illegal_q;

   // Decode of the incoming request
   logic [XLEN-1:0]   op_res;
   logic              op_illegal;
   logic              op_shift;
   shkind_t           op_kind;
   logic [4:0]        shamt;

   // One-bit step of the working register
   logic [XLEN-1:0]   work_d;

   assign shamt = SrcB[4:0];

   always_comb begin
      op_res     = '0;
      op_illegal = 1'b0;
      op_shift   = 1'b0;
      op_kind    = SH_SLL;
      case (ALUControl)
         4'b0000: op_res = SrcA + SrcB;
         4'b0001: op_res = SrcA - SrcB;
         4'b0010: op_res = SrcA & SrcB;
         4'b0011: op_res = SrcA | SrcB;
         4'b0100: begin op_shift = 1'b1; op_kind = SH_SLL; op_res = SrcA; end
         4'b0101: op_res = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
         4'b0110: begin op_shift = 1'b1; op_kind = SH_SRL; op_res = SrcA; end
         4'b0111: op_res = SrcA ^ SrcB;
         4'b1000: begin op_shift = 1'b1; op_kind = SH_SRA; op_res = SrcA; end
         4'b1001: op_res = {{(XLEN-1){1'b0}}, (SrcA < SrcB)};
         default: op_illegal = 1'b1;
      endcase
   end

   always_comb begin
      work_d = work_q;
      case (kind_q)
         SH_SLL:  work_d = {work_q[XLEN-2:0], 1'b0};
         SH_SRL:  work_d = {1'b0, work_q[XLEN-1:1]};
         SH_SRA:  work_d = {work_q[XLEN-1], work_q[XLEN-1:1]};
         default: work_d = work_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         kind_q    <= SH_SLL;
         work_q    <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
         zero_q    <= 1'b1;
         illegal_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  if (op_shift && (shamt != 5'd0)) begin
                     work_q  <= SrcA;
                     cnt_q   <= shamt;
                     kind_q  <= op_kind;
                     state_q <= SHIFT;
                  end else begin
                     // Non-shift, zero-length shift and unsupported codes all
                     // complete on the accepting edge.
                     result_q  <= op_res;
                     zero_q    <= (op_res == '0);
                     illegal_q <= op_illegal;
                     state_q   <= DONE;
                  end
               end else begin
                  state_q <= IDLE;
               end
            end
            SHIFT: begin
               work_q <= work_d;
               cnt_q  <= cnt_q - 5'd1;
               // Last step: publish the shifted value directly so the result
               // lands on the same edge the counter reaches zero.
               if (cnt_q == 5'd1) begin
                  result_q  <= work_d;
                  zero_q    <= (work_d == '0);
                  illegal_q <= 1'b0;
                  state_q   <= DONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy      = (state_q == SHIFT);
   assign done      = (state_q == DONE);
   assign ALUResult = result_q;
   assign Zero      = zero_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  ALUControl;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        busy;
   logic        done;
   logic [31:0] ALUResult;
   logic        Zero;
   logic        illegal;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [31:0] res;
      logic        zero;
      logic        ill;
      int          lat;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   seq_alu #(.XLEN(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .ALUControl (ALUControl),
      .SrcA       (SrcA),
      .SrcB       (SrcB),
      .busy       (busy),
      .done       (done),
      .ALUResult  (ALUResult),
      .Zero       (Zero),
      .illegal    (illegal)
   );

   // Drive one request for a single edge; returns 1 time unit after that edge.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      ALUControl = op;
      SrcA       = a;
      SrcB       = b;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Waits (bounded) for done. lat counts edges from the accepting edge.
   task automatic wait_done(input logic [31:0] prev, output int lat, output int nbusy,
                            output bit held, output bit seen);
      lat = 1; nbusy = 0; held = 1'b1; seen = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) nbusy++;
         if (ALUResult !== prev) held = 1'b0;
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      int unsigned sh;
      sh    = b[4:0];
      e.res = 32'h0; e.ill = 1'b0; e.lat = 1;
      case (op)
         4'd0: e.res = a + b;
         4'd1: e.res = a - b;
         4'd2: e.res = a & b;
         4'd3: e.res = a | b;
         4'd4: begin e.res = a << sh; e.lat = (sh == 0) ? 1 : sh + 1; end
         4'd5: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd6: begin e.res = a >> sh; e.lat = (sh == 0) ? 1 : sh + 1; end
         4'd7: e.res = a ^ b;
         4'd8: begin e.res = $unsigned($signed(a) >>> sh); e.lat = (sh == 0) ? 1 : sh + 1; end
         4'd9: e.res = (a < b) ? 32'd1 : 32'd0;
         default: e.ill = 1'b1;
      endcase
      e.zero = (e.res == 32'h0);
      return e;
   endfunction

   task automatic test_reset();
      start = 1'b0; ALUControl = 4'h0; SrcA = '0; SrcB = '0;
      reset = 1'b0;
      #1 reset = 1'b1;
      #1;
      n_tests++; if (busy !== 1'b0)          begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_tests++; if (done !== 1'b0)          begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
      n_tests++; if (ALUResult !== 32'h0)    begin n_fail++; $display("FAIL reset_result: got %h expected 00000000", ALUResult); end
      n_tests++; if (Zero !== 1'b1)          begin n_fail++; $display("FAIL reset_zero: got %b expected 1", Zero); end
      n_tests++; if (illegal !== 1'b0)       begin n_fail++; $display("FAIL reset_illegal: got %b expected 0", illegal); end
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_add_sub();
      logic [3:0]  ops [2] = '{4'b0000, 4'b0001};
      logic [31:0] as  [2] = '{32'h7FFF_FFFF, 32'd5};
      logic [31:0] bs  [2] = '{32'd1, 32'd5};
      exp_t e; int lat, nb; bit held, seen;
      sb.push_back('{res: 32'h8000_0000, zero: 1'b0, ill: 1'b0, lat: 1});
      sb.push_back('{res: 32'h0,         zero: 1'b1, ill: 1'b0, lat: 1});
      for (int i = 0; i < 2; i++) begin
         issue(ops[i], as[i], bs[i]);
         wait_done(ALUResult, lat, nb, held, seen);
         e = sb.pop_front();
         n_tests++; if (!seen)              begin n_fail++; $display("FAIL addsub%0d_timeout: no done seen, expected done", i); end
         n_tests++; if (lat != e.lat)       begin n_fail++; $display("FAIL addsub%0d_latency: got %0d expected %0d", i, lat, e.lat); end
         n_tests++; if (ALUResult !== e.res) begin n_fail++; $display("FAIL addsub%0d_result: got %h expected %h", i, ALUResult, e.res); end
         n_tests++; if (Zero !== e.zero)    begin n_fail++; $display("FAIL addsub%0d_zero: got %b expected %b", i, Zero, e.zero); end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_sra();
      exp_t e; int lat, nb; bit held, seen; logic [31:0] prev;
      prev = ALUResult;
      sb.push_back('{res: 32'hF800_0000, zero: 1'b0, ill: 1'b0, lat: 5});
      issue(4'b1000, 32'h8000_0000, 32'h0000_0024);
      wait_done(prev, lat, nb, held, seen);
      e = sb.pop_front();
      n_tests++; if (!seen)               begin n_fail++; $display("FAIL sra_timeout: no done seen, expected done"); end
      n_tests++; if (nb != 4)             begin n_fail++; $display("FAIL sra_busy_cycles: got %0d expected 4", nb); end
      n_tests++; if (lat != e.lat)        begin n_fail++; $display("FAIL sra_latency: got %0d expected %0d", lat, e.lat); end
      n_tests++; if (!held)               begin n_fail++; $display("FAIL sra_result_held: result changed during shift, expected held %h", prev); end
      n_tests++; if (ALUResult !== e.res) begin n_fail++; $display("FAIL sra_result: got %h expected %h", ALUResult, e.res); end
      n_tests++; if (Zero !== e.zero)     begin n_fail++; $display("FAIL sra_zero: got %b expected %b", Zero, e.zero); end
      @(posedge clk); #1;
      n_tests++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL sra_return_idle: got done=%b busy=%b expected 0 0", done, busy); end
   endtask

   task automatic test_slt();
      logic [3:0] ops [2] = '{4'b0101, 4'b1001};
      exp_t e; int lat, nb; bit held, seen;
      sb.push_back('{res: 32'd1, zero: 1'b0, ill: 1'b0, lat: 1});
      sb.push_back('{res: 32'd0, zero: 1'b1, ill: 1'b0, lat: 1});
      for (int i = 0; i < 2; i++) begin
         issue(ops[i], 32'hFFFF_FFFF, 32'd1);
         wait_done(ALUResult, lat, nb, held, seen);
         e = sb.pop_front();
         n_tests++; if (!seen || lat != 1)   begin n_fail++; $display("FAIL slt%0d_latency: got %0d seen=%b expected 1", i, lat, seen); end
         n_tests++; if (ALUResult !== e.res) begin n_fail++; $display("FAIL slt%0d_result: got %h expected %h", i, ALUResult, e.res); end
         n_tests++; if (Zero !== e.zero)     begin n_fail++; $display("FAIL slt%0d_zero: got %b expected %b", i, Zero, e.zero); end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_srl_ignore();
      exp_t e; int lat; bit seen;
      sb.push_back('{res: 32'h0000_000F, zero: 1'b0, ill: 1'b0, lat: 5});
      issue(4'b0110, 32'h0000_00F0, 32'h0000_0004);
      lat = 1; seen = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (done) begin seen = 1'b1; break; end
         start = 1'b1; ALUControl = 4'b0000;
         SrcA = $urandom; SrcB = $urandom;
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      e = sb.pop_front();
      n_tests++; if (!seen)               begin n_fail++; $display("FAIL srl_timeout: no done seen, expected done"); end
      n_tests++; if (lat != e.lat)        begin n_fail++; $display("FAIL srl_latency: got %0d expected %0d", lat, e.lat); end
      n_tests++; if (ALUResult !== e.res) begin n_fail++; $display("FAIL srl_result: got %h expected %h", ALUResult, e.res); end
      @(posedge clk); #1;
      n_tests++; if (done !== 1'b0 || ALUResult !== 32'h0000_000F) begin n_fail++; $display("FAIL srl_after: got done=%b result=%h expected 0 0000000f", done, ALUResult); end
   endtask

   task automatic test_reset_mid_shift();
      exp_t e; int lat, nb, ndone; bit held, seen;
      issue(4'b0100, 32'h0000_0001, 32'd31);
      repeat (9) begin @(posedge clk); #1; end
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midreset_busy_before: got %b expected 1", busy); end
      #2 reset = 1'b1;
      #1;
      n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midreset_flags: got busy=%b done=%b expected 0 0", busy, done); end
      n_tests++; if (ALUResult !== 32'h0) begin n_fail++; $display("FAIL midreset_result: got %h expected 00000000", ALUResult); end
      n_tests++; if (Zero !== 1'b1 || illegal !== 1'b0) begin n_fail++; $display("FAIL midreset_zero_ill: got %b %b expected 1 0", Zero, illegal); end
      @(posedge clk); #1;
      reset = 1'b0;
      ndone = 0;
      repeat (40) begin
         if (done) ndone++;
         @(posedge clk); #1;
      end
      n_tests++; if (ndone != 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d done cycles expected 0", ndone); end
      sb.push_back('{res: 32'h0000_00F0, zero: 1'b0, ill: 1'b0, lat: 1});
      issue(4'b0111, 32'h0000_00FF, 32'h0000_000F);
      wait_done(ALUResult, lat, nb, held, seen);
      e = sb.pop_front();
      n_tests++; if (!seen || lat != e.lat) begin n_fail++; $display("FAIL xor_latency: got %0d seen=%b expected %0d", lat, seen, e.lat); end
      n_tests++; if (ALUResult !== e.res)   begin n_fail++; $display("FAIL xor_result: got %h expected %h", ALUResult, e.res); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      exp_t e; int lat, nb; bit held, seen;
      sb.push_back('{res: 32'h0, zero: 1'b1, ill: 1'b1, lat: 1});
      issue(4'b1011, 32'h1234_5678, 32'h9ABC_DEF0);
      wait_done(ALUResult, lat, nb, held, seen);
      e = sb.pop_front();
      n_tests++; if (!seen || lat != e.lat) begin n_fail++; $display("FAIL illegal_latency: got %0d seen=%b expected %0d", lat, seen, e.lat); end
      n_tests++; if (illegal !== e.ill)     begin n_fail++; $display("FAIL illegal_flag: got %b expected %b", illegal, e.ill); end
      n_tests++; if (ALUResult !== e.res || Zero !== e.zero) begin n_fail++; $display("FAIL illegal_result: got %h/%b expected %h/%b", ALUResult, Zero, e.res, e.zero); end
      // Second start issued in the DONE cycle of the illegal op.
      sb.push_back('{res: 32'd7, zero: 1'b0, ill: 1'b0, lat: 1});
      issue(4'b0000, 32'd3, 32'd4);
      wait_done(ALUResult, lat, nb, held, seen);
      e = sb.pop_front();
      n_tests++; if (!seen || lat != e.lat) begin n_fail++; $display("FAIL b2b_latency: got %0d seen=%b expected %0d", lat, seen, e.lat); end
      n_tests++; if (ALUResult !== e.res)   begin n_fail++; $display("FAIL b2b_result: got %h expected %h", ALUResult, e.res); end
      n_tests++; if (illegal !== e.ill)     begin n_fail++; $display("FAIL b2b_illegal: got %b expected %b", illegal, e.ill); end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      exp_t e; int lat, nb; bit held, seen;
      logic [3:0] op; logic [31:0] a, b;
      for (int i = 0; i < 30; i++) begin
         op = 4'($urandom_range(0, 15));
         a  = $urandom;
         b  = $urandom;
         if (i % 5 == 0) b[4:0] = 5'd0;   // zero-length shifts with upper bits set
         sb.push_back(model(op, a, b));
         issue(op, a, b);
         wait_done(ALUResult, lat, nb, held, seen);
         e = sb.pop_front();
         n_tests++;
         if (!seen || lat != e.lat || ALUResult !== e.res || Zero !== e.zero || illegal !== e.ill) begin
            n_fail++;
            $display("FAIL rand%0d op=%h a=%h b=%h: got lat=%0d res=%h z=%b ill=%b expected lat=%0d res=%h z=%b ill=%b",
                     i, op, a, b, lat, ALUResult, Zero, illegal, e.lat, e.res, e.zero, e.ill);
         end
         if (i % 3 == 0) begin @(posedge clk); #1; end
      end
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_sra();
      test_slt();
      test_srl_ignore();
      test_reset_mid_shift();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1);
   end

endmodule
